// File: rtl/dem_seq_ctrl_pkg.sv
// dem_pkg: shared types and constants for the Dem sequence controller
package dem_pkg;
  localparam int DATA_W = 3;
  localparam int MAX_LEN = 8;
  localparam logic [7:0] VALID_START_MASK = 8'b0111_1101;
  localparam logic [3*8-1:0] SEQ = {3'd2, 3'd3, 3'd5, 3'd2, 3'd0, 3'd3, 3'd4, 3'd6};
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DONE} state_e;
  function automatic logic [DATA_W-1:0] seq_at(int unsigned i);
    return SEQ[3*(7-(i%8)) +: 3];
  endfunction
  function automatic logic job_ok(logic [DATA_W-1:0] start, int unsigned len);
    return VALID_START_MASK[start] && len >= 1 && len <= MAX_LEN;
  endfunction
endpackage

// File: rtl/dem_seq_ctrl_if.sv
// dem_seq_ctrl_if: requester, counter and sample-stream signals; slave = controller, master = environment
interface dem_seq_ctrl_if
  import dem_pkg::*;
#(
  parameter int LEN_W = 4
) ();
  logic req0, req1;
  logic [DATA_W-1:0] start0, start1;
  logic [LEN_W-1:0] len0, len1;
  logic ack0, ack1, err;
  logic cnt_load;
  logic [DATA_W-1:0] cnt_in_data, cnt_out;
  logic out_valid, out_id, out_last;
  logic [DATA_W-1:0] out_data;
  modport slave (
    input req0, req1, start0, start1, len0, len1, cnt_out,
    output ack0, ack1, err, cnt_load, cnt_in_data, out_valid, out_data, out_id, out_last
  );
  modport master (
    output req0, req1, start0, start1, len0, len1, cnt_out,
    input ack0, ack1, err, cnt_load, cnt_in_data, out_valid, out_data, out_id, out_last
  );
endinterface

// File: rtl/dem_seq_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; ports clk, rst (sync active-low), req[1:0], en (commit grant), gnt_id
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic       gnt_id
);
  logic last;
  assign gnt_id = (req[0] & req[1]) ? ~last : req[1];
  always_ff @(posedge clk) begin
    if (!rst) last <= 1'b1;
    else if (en && |req) last <= gnt_id;
  end
endmodule

// File: rtl/dem_seq_ctrl.sv
// dem_seq_ctrl: shares one Dem counter between two requesters; ports clk, rst (sync active-low), bus (slave: req/start/len in, ack/err, counter load, sample stream out)
module dem_seq_ctrl
  import dem_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  dem_seq_ctrl_if.slave  bus
);
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] LOAD = ST_LOAD;
  localparam logic [1:0] RUN  = ST_RUN;
  localparam logic [1:0] DONE = ST_DONE;
  logic [1:0] state;
  logic [DATA_W-1:0] start_q, gnt_start, data_q;
  logic [LEN_W-1:0] rem, gnt_len;
  logic id_q, err_q, gnt_id, valid_q, sid_q, last_q, gnt_ok;
  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({bus.req1, bus.req0}),
    .en     (state == IDLE),
    .gnt_id (gnt_id)
  );
  assign gnt_start = gnt_id ? bus.start1 : bus.start0;
  assign gnt_len = gnt_id ? bus.len1 : bus.len0;
  assign gnt_ok = job_ok(gnt_start, 32'(gnt_len));
  assign bus.cnt_load = state == LOAD;
  assign bus.cnt_in_data = (state == LOAD) ? start_q : '0;
  assign bus.ack0 = (state == DONE) & ~id_q;
  assign bus.ack1 = (state == DONE) & id_q;
  assign bus.err = (state == DONE) & err_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data = data_q;
  assign bus.out_id = sid_q;
  assign bus.out_last = last_q;
  // RUN spends len sampling cycles plus one drain cycle, so ack lands the cycle after out_last
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      start_q <= '0;
      rem <= '0;
      id_q <= 1'b0;
      err_q <= 1'b0;
      valid_q <= 1'b0;
      data_q <= '0;
      sid_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      last_q <= 1'b0;
      case (state)
        IDLE: if (bus.req0 | bus.req1) begin
          start_q <= gnt_start;
          rem <= gnt_len;
          id_q <= gnt_id;
          err_q <= ~gnt_ok;
          state <= gnt_ok ? LOAD : DONE;
        end
        LOAD: state <= RUN;
        RUN: if (rem != '0) begin
          valid_q <= 1'b1;
          data_q <= bus.cnt_out;
          sid_q <= id_q;
          last_q <= rem == LEN_W'(1);
          rem <= rem - LEN_W'(1);
        end else state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dem_seq_ctrl.sv
// tb_dem_seq_ctrl: scoreboard bench for dem_seq_ctrl with a behavioural Dem counter
module tb_dem_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  dem_seq_ctrl_if #(.LEN_W(4)) bif ();
  dem_seq_ctrl #(.LEN_W(4)) dut (.clk(clk), .rst(rst), .bus(bif));
  logic [2:0] seq_tab [8] = '{3'd2, 3'd3, 3'd5, 3'd2, 3'd0, 3'd3, 3'd4, 3'd6};
  logic [2:0] dem_idx;
  function automatic logic [2:0] first_idx(logic [2:0] v);
    for (int i = 0; i < 8; i++) if (seq_tab[i] == v) return 3'(i);
    return 3'd0;
  endfunction
  always @(posedge clk) begin
    if (!rst) dem_idx <= 3'd0;
    else if (bif.cnt_load) dem_idx <= first_idx(bif.cnt_in_data);
    else dem_idx <= dem_idx + 3'd1;
  end
  assign bif.cnt_out = seq_tab[dem_idx];
  typedef struct {
    int kind;
    int data;
    int id;
    int flag;
  } ev_t;
  ev_t q[$];
  task automatic push(int kind, int data, int id, int flag);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.id = id;
    e.flag = flag;
    q.push_back(e);
  endtask
  task automatic expect_job(int id, int start, int len, bit legal, logic [23:0] samples);
    if (legal) begin
      push(0, start, 0, 0);
      for (int k = 0; k < len; k++) push(1, int'((samples >> (3*(len-1-k))) & 24'd7), id, int'(k == len-1));
    end
    push(2, 0, id, int'(!legal));
  endtask
  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic pop_cmp(string nm, int kind, int data, int id, int flag);
    ev_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_err++;
      $display("FAIL %s: unexpected event data=%0d id=%0d flag=%0d with nothing expected", nm, data, id, flag);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.data != data || e.id != id || e.flag != flag) begin
        n_err++;
        $display("FAIL %s: got kind=%0d data=%0d id=%0d flag=%0d expected kind=%0d data=%0d id=%0d flag=%0d",
                 nm, kind, data, id, flag, e.kind, e.data, e.id, e.flag);
      end
    end
  endtask
  always @(negedge clk) begin
    if (bif.cnt_load) pop_cmp("load", 0, int'(bif.cnt_in_data), 0, 0);
    if (bif.out_valid) pop_cmp("sample", 1, int'(bif.out_data), int'(bif.out_id), int'(bif.out_last));
    if (bif.ack0 & bif.ack1) chk("dual_ack", 1, 0);
    else if (bif.ack0 | bif.ack1) pop_cmp("ack", 2, 0, int'(bif.ack1), int'(bif.err));
  end
  function automatic int all_outs();
    return int'({bif.ack0, bif.ack1, bif.err, bif.cnt_load, bif.cnt_in_data,
                 bif.out_valid, bif.out_data, bif.out_id, bif.out_last});
  endfunction
  task automatic set_req(int id, bit r, int start, int len);
    if (id == 0) begin
      bif.start0 = 3'(start);
      bif.len0 = 4'(len);
      bif.req0 = r;
    end else begin
      bif.start1 = 3'(start);
      bif.len1 = 4'(len);
      bif.req1 = r;
    end
  endtask
  task automatic wait_ack(int id, int lat);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      seen = (id == 0) ? bif.ack0 : bif.ack1;
    end
    if (!seen) chk($sformatf("ack%0d_timeout", id), 0, 1);
    else if (lat != 0) chk($sformatf("ack%0d_latency", id), n, lat);
    @(posedge clk);
    #1;
    if (id == 0) bif.req0 = 1'b0;
    else bif.req1 = 1'b0;
  endtask
  task automatic do_job(int id, int start, int len, int lat);
    set_req(id, 1'b1, start, len);
    wait_ack(id, lat);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int k;
    set_req(0, 1'b0, 0, 0);
    set_req(1, 1'b0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", all_outs(), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    expect_job(0, 0, 4, 1, 24'o0346);
    do_job(0, 0, 4, 8);
    expect_job(1, 5, 3, 1, 24'o520);
    do_job(1, 5, 3, 7);
    expect_job(1, 2, 3, 1, 24'o235);
    do_job(1, 2, 3, 7);
    expect_job(1, 3, 3, 1, 24'o352);
    do_job(1, 3, 3, 7);
    expect_job(0, 4, 2, 1, 24'o46);
    expect_job(1, 6, 2, 1, 24'o62);
    expect_job(0, 0, 2, 1, 24'o03);
    expect_job(1, 5, 1, 1, 24'o5);
    fork
      begin
        do_job(0, 4, 2, 0);
        @(posedge clk);
        #1;
        do_job(0, 0, 2, 0);
      end
      begin
        do_job(1, 6, 2, 0);
        @(posedge clk);
        #1;
        do_job(1, 5, 1, 0);
      end
    join
    expect_job(0, 6, 8, 1, 24'o62352034);
    do_job(0, 6, 8, 12);
    expect_job(0, 7, 2, 0, 24'o0);
    do_job(0, 7, 2, 2);
    expect_job(0, 1, 2, 0, 24'o0);
    do_job(0, 1, 2, 2);
    expect_job(0, 2, 0, 0, 24'o0);
    do_job(0, 2, 0, 2);
    expect_job(0, 2, 9, 0, 24'o0);
    do_job(0, 2, 9, 2);
    push(0, 0, 0, 0);
    push(1, 0, 0, 0);
    push(1, 3, 0, 0);
    set_req(0, 1'b1, 0, 4);
    k = 0;
    for (int i = 0; i < 50 && k < 2; i++) begin
      @(negedge clk);
      if (bif.out_valid) k++;
    end
    chk("abort_samples_seen", k, 2);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_outputs", all_outs(), 0);
    chk("abort_queue", q.size(), 0);
    expect_job(0, 0, 4, 1, 24'o0346);
    rst = 1'b1;
    wait_ack(0, 0);
    repeat (5) @(negedge clk);
    chk("final_queue", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
